// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte producers,
// with optional packet lock and a watchdog on the transmitter's busy handshake.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int PKT_LOCK     = 1,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tx_send,
    output logic [7:0]                 tx_din,
    input  logic                       tx_busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       active,
    output logic                       err_timeout
);

    localparam int IDW = $clog2(N_REQ);
    localparam int TW  = $clog2(BUSY_TIMEOUT + 2);
    localparam logic [IDW:0]   NREQ_W  = (IDW + 1)'(N_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);
    localparam logic [TW-1:0]  TMAX    = TW'(BUSY_TIMEOUT);

    typedef enum logic [2:0] {IDLE, LAUNCH, FRAME, RELEASE, ABORT} arbState;

    arbState            state, stateNext;
    logic [IDW-1:0]     ptr, ptrNext, grantNext, winIdx, rotOffset, nextPtr;
    logic               lock, lockNext, lastQ, lastNext, errNext, winValid;
    logic [TW-1:0]      timer, timerNext;
    logic [7:0]         dinNext;
    logic [N_REQ-1:0]   readyNext, rotValid;
    logic [2*N_REQ-1:0] dblValid;
    logic [IDW:0]       winSum;
    logic [7:0]         reqBytes [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign reqBytes[gi]  = req_data[8*gi +: 8];
            assign readyNext[gi] = (stateNext == RELEASE) && (grant_id == IDW'(gi));
        end
    endgenerate

    // Rotate the valid vector so bit 0 is the requester at ptr; lowest set bit wins.
    assign dblValid = {req_valid, req_valid};
    assign rotValid = N_REQ'(dblValid >> ptr);

    always_comb begin
        rotOffset = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rotValid[j]) rotOffset = IDW'(j);
        end
    end

    assign winSum  = {1'b0, ptr} + {1'b0, rotOffset};
    assign nextPtr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    always_comb begin
        if (lock) begin
            winIdx   = grant_id;
            winValid = req_valid[grant_id];
        end else begin
            winIdx   = (winSum >= NREQ_W) ? IDW'(winSum - NREQ_W) : IDW'(winSum);
            winValid = |req_valid;
        end
    end

    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        lockNext  = lock;
        lastNext  = lastQ;
        timerNext = timer;
        dinNext   = tx_din;
        grantNext = grant_id;
        errNext   = err_timeout;
        case (state)
            IDLE: begin
                if (winValid) begin
                    dinNext   = reqBytes[winIdx];
                    lastNext  = req_last[winIdx];
                    grantNext = winIdx;
                    timerNext = '0;
                    stateNext = LAUNCH;
                end
            end
            LAUNCH: begin
                if (tx_busy) begin
                    stateNext = FRAME;
                end else if (timer == TMAX) begin
                    errNext   = 1'b1;
                    stateNext = ABORT;
                end else begin
                    timerNext = timer + 1'b1;
                end
            end
            FRAME: begin
                if (!tx_busy) stateNext = RELEASE;
            end
            RELEASE: begin
                ptrNext   = nextPtr;
                lockNext  = (PKT_LOCK != 0) && !lastQ;
                stateNext = IDLE;
            end
            ABORT: begin
                // The byte stays pending at its requester and is retried later.
                ptrNext   = nextPtr;
                lockNext  = 1'b0;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            lock        <= 1'b0;
            lastQ       <= 1'b0;
            timer       <= '0;
            tx_send     <= 1'b0;
            tx_din      <= '0;
            req_ready   <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= stateNext;
            ptr         <= ptrNext;
            lock        <= lockNext;
            lastQ       <= lastNext;
            timer       <= timerNext;
            tx_send     <= (stateNext == LAUNCH) || (stateNext == FRAME);
            tx_din      <= dinNext;
            req_ready   <= readyNext;
            grant_id    <= grantNext;
            active      <= (stateNext != IDLE);
            err_timeout <= errNext;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: packet producers, a stub transmitter with
// random busy timing, and a transaction-level arbitration model.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int PKT_LOCK = 1;
    localparam int BT       = 16;
    localparam int IDW      = $clog2(N);
    localparam int P_IDLE = 0, P_WAIT = 1, P_FRAME = 2, P_GAP = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_last, req_ready;
    logic [8*N-1:0]   req_data;
    logic             tx_send, tx_busy, active, err_timeout;
    logic [7:0]       tx_din;
    logic [IDW-1:0]   grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .PKT_LOCK(PKT_LOCK), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_send(tx_send),
        .tx_din(tx_din), .tx_busy(tx_busy), .grant_id(grant_id),
        .active(active), .err_timeout(err_timeout)
    );

    int errors = 0;
    int checks = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Producer queues: {last, data} per byte.
    logic [8:0] q [N][$];
    int         startAt [N];

    // Reference model state.
    int         mPtr, mGrant, mLock, mErr, mLast, phase, launchAt;
    logic [7:0] mData;
    int         frames, aborts, resets;

    // Stub transmitter state.
    int txSt, txCnt, txLen;
    bit deadMode;
    int rstCnt;

    function automatic int pick(input logic [N-1:0] v);
        if (mLock != 0) return v[mGrant] ? mGrant : -1;
        for (int j = 0; j < N; j++) begin
            if (v[(mPtr + j) % N]) return (mPtr + j) % N;
        end
        return -1;
    endfunction

    initial begin
        int w;
        rst = 1'b1; rstCnt = 2;
        req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
        txSt = 0; txCnt = 0; txLen = 0; deadMode = 1'b0;
        mPtr = 0; mGrant = 0; mLock = 0; mErr = 0; mLast = 0; phase = P_IDLE;
        launchAt = 0; mData = '0; frames = 0; aborts = 0; resets = 0;
        for (int i = 0; i < N; i++) startAt[i] = 0;

        for (int k = 1; k <= 4000; k++) begin
            @(posedge clk);
            #1;
            // ---- checks: current TB-driven values are what the DUT sampled at this edge
            if (rst) begin
                checkVal("rst_send", tx_send, 0);
                checkVal("rst_din", tx_din, 0);
                checkVal("rst_ready", req_ready, 0);
                checkVal("rst_grant", grant_id, 0);
                checkVal("rst_active", active, 0);
                checkVal("rst_err", err_timeout, 0);
                mPtr = 0; mGrant = 0; mLock = 0; mErr = 0; phase = P_IDLE;
            end else begin
                case (phase)
                    P_IDLE: begin
                        w = pick(req_valid);
                        if (w >= 0) begin
                            checkVal("launch_send", tx_send, 1);
                            checkVal("launch_grant", grant_id, w);
                            checkVal("launch_din", tx_din, req_data[8*w +: 8]);
                            checkVal("launch_active", active, 1);
                            mGrant = w; mData = req_data[8*w +: 8]; mLast = req_last[w];
                            launchAt = k; phase = P_WAIT;
                        end else begin
                            checkVal("idle_send", tx_send, 0);
                            checkVal("idle_active", active, 0);
                            checkVal("idle_ready", req_ready, 0);
                        end
                    end
                    P_WAIT: begin
                        if (tx_busy) begin
                            checkVal("frame_send", tx_send, 1);
                            phase = P_FRAME;
                        end else if (k - launchAt == BT + 1) begin
                            checkVal("abort_send", tx_send, 0);
                            checkVal("abort_ready", req_ready, 0);
                            checkVal("abort_active", active, 1);
                            mErr = 1; mLock = 0; mPtr = (mGrant + 1) % N;
                            aborts++; phase = P_GAP;
                        end else begin
                            checkVal("launch_hold", tx_send, 1);
                            checkVal("launch_ready", req_ready, 0);
                        end
                    end
                    P_FRAME: begin
                        if (!tx_busy) begin
                            checkVal("release_ready", req_ready, 1 << mGrant);
                            checkVal("release_send", tx_send, 0);
                            checkVal("release_active", active, 1);
                            mPtr = (mGrant + 1) % N;
                            mLock = (PKT_LOCK != 0 && mLast == 0) ? 1 : 0;
                            frames++; phase = P_GAP;
                        end else begin
                            checkVal("frame_din", tx_din, mData);
                            checkVal("frame_send", tx_send, 1);
                            checkVal("frame_ready", req_ready, 0);
                        end
                    end
                    default: begin
                        checkVal("gap_send", tx_send, 0);
                        checkVal("gap_active", active, 0);
                        checkVal("gap_ready", req_ready, 0);
                        phase = P_IDLE;
                    end
                endcase
                checkVal("grant_hold", grant_id, mGrant);
                checkVal("err_sticky", err_timeout, mErr);
            end

            // ---- producers consume their handshake
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && q[i].size() > 0) begin
                    void'(q[i].pop_front());
                    startAt[i] = k + 1 + $urandom_range(0, 4);
                end
            end

            // ---- reset scheduling: once mid-frame, later in the run
            if (k >= 2500 && resets == 0 && phase == P_FRAME && !rst) begin
                rstCnt = 2; resets++;
            end
            if (rstCnt > 0) begin
                rst = 1'b1; rstCnt--;
            end else begin
                rst = 1'b0;
            end

            // ---- stub transmitter; a window where busy never rises forces timeouts
            deadMode = (k >= 1500 && k < 1800);
            if (rst) begin
                txSt = 0; tx_busy = 1'b0;
            end else begin
                case (txSt)
                    0: if (tx_send && !deadMode) begin
                        txCnt = $urandom_range(0, 2);
                        if (txCnt == 0) begin
                            tx_busy = 1'b1; txLen = $urandom_range(1, 6); txSt = 2;
                        end else begin
                            txSt = 1;
                        end
                    end
                    1: begin
                        txCnt--;
                        if (txCnt == 0) begin
                            tx_busy = 1'b1; txLen = $urandom_range(1, 6); txSt = 2;
                        end
                    end
                    2: begin
                        txLen--;
                        if (txLen == 0) begin
                            tx_busy = 1'b0; txSt = 3;
                        end
                    end
                    default: if (!tx_send) txSt = 0;
                endcase
            end

            // ---- producer refill and drive
            for (int i = 0; i < N; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++)
                        q[i].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                    if (startAt[i] <= k) startAt[i] = k + 1 + $urandom_range(0, 3);
                end
                if (q[i].size() > 0 && k >= startAt[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = q[i][0][7:0];
                    req_last[i]        = q[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'($urandom);
                    req_last[i]        = 1'($urandom);
                end
            end
        end

        checkVal("frames_completed", (frames > 100) ? 1 : 0, 1);
        checkVal("timeouts_seen", (aborts > 0) ? 1 : 0, 1);
        checkVal("reset_mid_frame", resets, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
